// File: rtl/set_assoc_cache_sim_if.sv
// Trace access handshake between the SD trace decoder and the cache simulator.
// One decoded access moves per acc_valid && acc_ready cycle.
interface set_assoc_cache_sim_if #(
  parameter int TAG_W   = 17,
  parameter int INDEX_W = 11
);
  logic               acc_valid;
  logic               acc_ready;
  logic [TAG_W-1:0]   acc_tag;
  logic [INDEX_W-1:0] acc_index;
  logic               acc_store;

  modport master (
    output acc_valid,
    output acc_tag,
    output acc_index,
    output acc_store,
    input  acc_ready
  );

  modport slave (
    input  acc_valid,
    input  acc_tag,
    input  acc_index,
    input  acc_store,
    output acc_ready
  );
endinterface

// File: rtl/set_assoc_cache_sim.sv
// N-way set-associative cache simulator with true-LRU ages per set.
// Tracks tag/valid/dirty state and drives saturating hit/miss statistics.
module set_assoc_cache_sim #(
  parameter int TAG_W       = 17,
  parameter int INDEX_W     = 11,
  parameter int WAYS        = 4,
  parameter int WRITE_ALLOC = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             clear,
  set_assoc_cache_sim_if.slave acc,
  output logic             busy,
  output logic [CNT_W-1:0] accesses_total,
  output logic [CNT_W-1:0] hit_total,
  output logic [CNT_W-1:0] miss_total,
  output logic [CNT_W-1:0] read_hit_total,
  output logic [CNT_W-1:0] write_hit_total,
  output logic [CNT_W-1:0] read_miss_total,
  output logic [CNT_W-1:0] write_miss_total,
  output logic [CNT_W-1:0] eviction_total,
  output logic [CNT_W-1:0] writeback_total
);
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SETS  = 1 << INDEX_W;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    logic [AGE_W-1:0] age;
  } line_t;

  typedef line_t [WAYS-1:0] set_t;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    LOOKUP,
    UPDATE
  } state_t;

  state_t             state, state_n;
  logic [INDEX_W-1:0] init_idx;
  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               req_store;

  set_t               mem [SETS];
  set_t               rd_set;
  set_t               wr_set;
  set_t               init_set;

  logic               accept;
  logic               hit;
  logic               inv_found;
  logic               alloc;
  logic               mem_we;
  logic [AGE_W-1:0]   hit_way;
  logic [AGE_W-1:0]   inv_way;
  logic [AGE_W-1:0]   lru_way;
  logic [AGE_W-1:0]   sel_way;
  logic [AGE_W-1:0]   sel_age;
  logic               sel_valid;
  logic               sel_dirty;

  logic               hit_q;
  logic               vic_valid_q;
  logic               vic_dirty_q;
  logic [AGE_W-1:0]   way_q;
  logic [AGE_W-1:0]   ref_age_q;

  logic [8:0]         inc;
  logic [CNT_W-1:0]   cnt [9];

  assign accept        = (state == IDLE) && start && acc.acc_valid;
  assign acc.acc_ready = (state == IDLE) && start;
  assign busy          = (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      INIT:    if (init_idx == '1) state_n = IDLE;
      IDLE:    if (accept) state_n = LOOKUP;
      LOOKUP:  state_n = UPDATE;
      UPDATE:  state_n = IDLE;
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state <= state_n;
      if (state == INIT) init_idx <= init_idx + 1'b1;
    end
  end

  // Descending scan so the lowest-index match wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    sel_age   = '0;
    sel_valid = 1'b0;
    sel_dirty = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd_set[w].valid && rd_set[w].tag == req_tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!rd_set[w].valid) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
      if (rd_set[w].age == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
    end
    sel_way = hit ? hit_way : (inv_found ? inv_way : lru_way);
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == sel_way) begin
        sel_age   = rd_set[w].age;
        sel_valid = rd_set[w].valid;
        sel_dirty = rd_set[w].dirty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_tag   <= acc.acc_tag;
      req_idx   <= acc.acc_index;
      req_store <= acc.acc_store;
    end
    if (state == LOOKUP) begin
      hit_q       <= hit;
      way_q       <= sel_way;
      ref_age_q   <= sel_age;
      vic_valid_q <= sel_valid;
      vic_dirty_q <= sel_dirty;
    end
  end

  always_comb begin
    alloc  = !hit_q && (!req_store || (WRITE_ALLOC != 0));
    wr_set = rd_set;
    for (int w = 0; w < WAYS; w++) begin
      init_set[w]     = '0;
      init_set[w].age = AGE_W'(w);
      if (AGE_W'(w) == way_q) begin
        wr_set[w].age = '0;
        if (hit_q) begin
          wr_set[w].dirty = rd_set[w].dirty | req_store;
        end else begin
          wr_set[w].valid = 1'b1;
          wr_set[w].tag   = req_tag;
          wr_set[w].dirty = req_store;
        end
      end else if (rd_set[w].age < ref_age_q) begin
        wr_set[w].age = rd_set[w].age + 1'b1;
      end
    end
    // A non-allocating store miss leaves the set untouched.
    mem_we = resetn && ((state == INIT) ||
             ((state == UPDATE) && (hit_q || alloc)));
    inc = '0;
    if (state == UPDATE) begin
      inc = {alloc & vic_valid_q & vic_dirty_q,
             alloc & vic_valid_q,
             !hit_q & req_store,
             !hit_q & !req_store,
             hit_q & req_store,
             hit_q & !req_store,
             !hit_q,
             hit_q,
             1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (state == INIT) mem[init_idx] <= init_set;
      else               mem[req_idx]  <= wr_set;
    end
    if (accept) rd_set <= mem[acc.acc_index];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 9; i++) begin
      if (!resetn || clear) begin
        cnt[i] <= '0;
      end else if (inc[i] && cnt[i] != '1) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign accesses_total   = cnt[0];
  assign hit_total        = cnt[1];
  assign miss_total       = cnt[2];
  assign read_hit_total   = cnt[3];
  assign write_hit_total  = cnt[4];
  assign read_miss_total  = cnt[5];
  assign write_miss_total = cnt[6];
  assign eviction_total   = cnt[7];
  assign writeback_total  = cnt[8];
endmodule

// File: tb/tb_set_assoc_cache_sim.sv
// Directed bench: 4-way allocating, 4-way non-allocating and
// direct-mapped 2-bit-counter instances, 8 sets each.
module tb_set_assoc_cache_sim;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        clear_a;
  logic [16:0] t_tag;
  logic [2:0]  t_idx;
  logic        t_st;
  logic [2:0]  vld;
  logic [2:0]  rdy;
  logic [2:0]  bsy;
  logic [31:0] ca [9];
  logic [31:0] cb [9];
  logic [1:0]  cc [9];
  int          cmp = 0;
  int          errs = 0;
  string       nm [9] = '{"accesses", "hit", "miss", "read_hit",
                          "write_hit", "read_miss", "write_miss",
                          "eviction", "writeback"};

  always #5 clk = ~clk;

  set_assoc_cache_sim_if #(.TAG_W(17), .INDEX_W(3)) ifa ();
  set_assoc_cache_sim_if #(.TAG_W(17), .INDEX_W(3)) ifb ();
  set_assoc_cache_sim_if #(.TAG_W(17), .INDEX_W(3)) ifc ();

  assign ifa.acc_valid = vld[0];
  assign ifb.acc_valid = vld[1];
  assign ifc.acc_valid = vld[2];
  assign ifa.acc_tag   = t_tag;
  assign ifb.acc_tag   = t_tag;
  assign ifc.acc_tag   = t_tag;
  assign ifa.acc_index = t_idx;
  assign ifb.acc_index = t_idx;
  assign ifc.acc_index = t_idx;
  assign ifa.acc_store = t_st;
  assign ifb.acc_store = t_st;
  assign ifc.acc_store = t_st;
  assign rdy[0] = ifa.acc_ready;
  assign rdy[1] = ifb.acc_ready;
  assign rdy[2] = ifc.acc_ready;

  set_assoc_cache_sim #(
    .TAG_W(17), .INDEX_W(3), .WAYS(4), .WRITE_ALLOC(1), .CNT_W(32)
  ) dut_a (
    .clk(clk), .resetn(resetn), .start(start), .clear(clear_a),
    .acc(ifa), .busy(bsy[0]),
    .accesses_total(ca[0]), .hit_total(ca[1]), .miss_total(ca[2]),
    .read_hit_total(ca[3]), .write_hit_total(ca[4]),
    .read_miss_total(ca[5]), .write_miss_total(ca[6]),
    .eviction_total(ca[7]), .writeback_total(ca[8])
  );

  set_assoc_cache_sim #(
    .TAG_W(17), .INDEX_W(3), .WAYS(4), .WRITE_ALLOC(0), .CNT_W(32)
  ) dut_b (
    .clk(clk), .resetn(resetn), .start(start), .clear(1'b0),
    .acc(ifb), .busy(bsy[1]),
    .accesses_total(cb[0]), .hit_total(cb[1]), .miss_total(cb[2]),
    .read_hit_total(cb[3]), .write_hit_total(cb[4]),
    .read_miss_total(cb[5]), .write_miss_total(cb[6]),
    .eviction_total(cb[7]), .writeback_total(cb[8])
  );

  set_assoc_cache_sim #(
    .TAG_W(17), .INDEX_W(3), .WAYS(1), .WRITE_ALLOC(1), .CNT_W(2)
  ) dut_c (
    .clk(clk), .resetn(resetn), .start(start), .clear(1'b0),
    .acc(ifc), .busy(bsy[2]),
    .accesses_total(cc[0]), .hit_total(cc[1]), .miss_total(cc[2]),
    .read_hit_total(cc[3]), .write_hit_total(cc[4]),
    .read_miss_total(cc[5]), .write_miss_total(cc[6]),
    .eviction_total(cc[7]), .writeback_total(cc[8])
  );

  task automatic acc(input int d, input logic [16:0] tag,
                     input logic [2:0] idx, input logic st);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmp++;
    if (!rdy[d]) begin
      $display("FAIL acc_ready_timeout dut=%0d got 0 want 1", d);
      errs++;
    end
    t_tag  = tag;
    t_idx  = idx;
    t_st   = st;
    vld[d] = 1'b1;
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
    t_tag  = '1;
    t_idx  = ~idx;
    t_st   = ~st;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    resetn = 1'b0;
    start  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp++;
    if (rdy !== 3'b000 || bsy !== 3'b111) begin
      $display("FAIL reset_hs got rdy=%b busy=%b want 000/111", rdy, bsy);
      errs++;
    end
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    while (!rdy[0] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    cmp++;
    if (n != 8) begin
      $display("FAIL init_len got %0d want 8", n);
      errs++;
    end
    for (int i = 0; i < 9; i++) begin
      cmp++;
      if (ca[i] !== 32'd0 || cb[i] !== 32'd0 || cc[i] !== 2'd0) begin
        $display("FAIL reset_%s got %0d/%0d/%0d want 0",
                 nm[i], ca[i], cb[i], cc[i]);
        errs++;
      end
    end
  endtask

  task automatic test_cold_fill();
    int e [9];
    acc(0, 17'd1, 3'd5, 1'b0);
    acc(0, 17'd2, 3'd5, 1'b0);
    acc(0, 17'd3, 3'd5, 1'b0);
    acc(0, 17'd4, 3'd5, 1'b0);
    acc(0, 17'd1, 3'd5, 1'b0);
    e = '{5, 1, 4, 1, 0, 4, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      cmp++;
      if (ca[i] !== 32'(e[i])) begin
        $display("FAIL cold_%s got %0d want %0d", nm[i], ca[i], e[i]);
        errs++;
      end
    end
  endtask

  task automatic test_lru_victim();
    int e [9];
    acc(0, 17'd5, 3'd5, 1'b0);
    cmp++;
    if (ca[7] !== 32'd1) begin
      $display("FAIL lru_evict5 got %0d want 1", ca[7]);
      errs++;
    end
    acc(0, 17'd2, 3'd5, 1'b0);
    cmp++;
    if (ca[2] !== 32'd6 || ca[7] !== 32'd2) begin
      $display("FAIL lru_tag2 got miss=%0d ev=%0d want 6/2", ca[2], ca[7]);
      errs++;
    end
    acc(0, 17'd2, 3'd5, 1'b0);
    acc(0, 17'd3, 3'd5, 1'b0);
    e = '{9, 2, 7, 2, 0, 7, 0, 3, 0};
    for (int i = 0; i < 9; i++) begin
      cmp++;
      if (ca[i] !== 32'(e[i])) begin
        $display("FAIL lru_%s got %0d want %0d", nm[i], ca[i], e[i]);
        errs++;
      end
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    t_tag  = 17'd5;
    t_idx  = 3'd5;
    t_st   = 1'b0;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear_a = 1'b1;
    @(posedge clk);
    #1;
    clear_a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cmp++;
      if (ca[i] !== 32'd0) begin
        $display("FAIL clear_%s got %0d want 0", nm[i], ca[i]);
        errs++;
      end
    end
    acc(0, 17'd3, 3'd5, 1'b0);
    cmp++;
    if (ca[1] !== 32'd1 || ca[2] !== 32'd0) begin
      $display("FAIL clear_keeps_lines got hit=%0d miss=%0d want 1/0",
               ca[1], ca[2]);
      errs++;
    end
  endtask

  task automatic test_dirty_writeback();
    int e [9];
    acc(0, 17'd9, 3'd2, 1'b1);
    acc(0, 17'd10, 3'd2, 1'b0);
    acc(0, 17'd11, 3'd2, 1'b0);
    acc(0, 17'd12, 3'd2, 1'b0);
    acc(0, 17'd13, 3'd2, 1'b0);
    e = '{6, 1, 5, 1, 0, 4, 1, 1, 1};
    for (int i = 0; i < 9; i++) begin
      cmp++;
      if (ca[i] !== 32'(e[i])) begin
        $display("FAIL wb_%s got %0d want %0d", nm[i], ca[i], e[i]);
        errs++;
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start  = 1'b0;
    t_tag  = 17'd30;
    t_idx  = 3'd6;
    t_st   = 1'b0;
    vld[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp++;
    if (rdy[0] !== 1'b0 || ca[0] !== 32'd6) begin
      $display("FAIL start_low got rdy=%b acc=%0d want 0/6", rdy[0], ca[0]);
      errs++;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    cmp++;
    if (rdy[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      $display("FAIL b2b_n got rdy=%b busy=%b want 0/1", rdy[0], bsy[0]);
      errs++;
    end
    @(posedge clk);
    #1;
    cmp++;
    if (rdy[0] !== 1'b0 || ca[0] !== 32'd6) begin
      $display("FAIL b2b_n1 got rdy=%b acc=%0d want 0/6", rdy[0], ca[0]);
      errs++;
    end
    @(posedge clk);
    #1;
    cmp++;
    if (rdy[0] !== 1'b1 || ca[0] !== 32'd7 || ca[2] !== 32'd6) begin
      $display("FAIL b2b_n2 got rdy=%b acc=%0d miss=%0d want 1/7/6",
               rdy[0], ca[0], ca[2]);
      errs++;
    end
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp++;
    if (ca[0] !== 32'd8 || ca[1] !== 32'd2) begin
      $display("FAIL b2b_second got acc=%0d hit=%0d want 8/2", ca[0], ca[1]);
      errs++;
    end
  endtask

  task automatic test_no_write_alloc();
    int e [9];
    acc(1, 17'd7, 3'd1, 1'b1);
    acc(1, 17'd7, 3'd1, 1'b0);
    acc(1, 17'd7, 3'd1, 1'b0);
    e = '{3, 1, 2, 1, 0, 1, 1, 0, 0};
    for (int i = 0; i < 9; i++) begin
      cmp++;
      if (cb[i] !== 32'(e[i])) begin
        $display("FAIL nwa_%s got %0d want %0d", nm[i], cb[i], e[i]);
        errs++;
      end
    end
  endtask

  task automatic test_direct_mapped_sat();
    int e [9];
    acc(2, 17'd1, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) acc(2, 17'd2, 3'd0, 1'b0);
    e = '{3, 3, 2, 3, 0, 2, 0, 1, 0};
    for (int i = 0; i < 9; i++) begin
      cmp++;
      if (cc[i] !== 2'(e[i])) begin
        $display("FAIL dm_sat_%s got %0d want %0d", nm[i], cc[i], e[i]);
        errs++;
      end
    end
    acc(2, 17'd3, 3'd0, 1'b1);
    acc(2, 17'd4, 3'd0, 1'b0);
    e = '{3, 3, 3, 3, 0, 3, 1, 3, 1};
    for (int i = 0; i < 9; i++) begin
      cmp++;
      if (cc[i] !== 2'(e[i])) begin
        $display("FAIL dm_evict_%s got %0d want %0d", nm[i], cc[i], e[i]);
        errs++;
      end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    @(negedge clk);
    t_tag  = 17'd3;
    t_idx  = 3'd5;
    t_st   = 1'b0;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    while (!rdy[0] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    cmp++;
    if (n != 8 || ca[0] !== 32'd0) begin
      $display("FAIL mid_reset got init=%0d acc=%0d want 8/0", n, ca[0]);
      errs++;
    end
    acc(0, 17'd3, 3'd5, 1'b0);
    cmp++;
    if (ca[1] !== 32'd0 || ca[2] !== 32'd1) begin
      $display("FAIL mid_reset_flush got hit=%0d miss=%0d want 0/1",
               ca[1], ca[2]);
      errs++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    vld     = '0;
    clear_a = 1'b0;
    t_tag   = '0;
    t_idx   = '0;
    t_st    = 1'b0;
    test_reset();
    test_cold_fill();
    test_lru_victim();
    test_clear();
    test_dirty_writeback();
    test_back_to_back();
    test_no_write_alloc();
    test_direct_mapped_sat();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/set_assoc_cache_sim.md
# set_assoc_cache_sim

Parametrised N-way set-associative cache simulator. It is the next generation of the direct-mapped LRU controller and sits between the SD trace decoder and the statistics/VGA path. It accepts one decoded trace access (tag, index, load/store) per handshake and keeps tag, valid, dirty and true-LRU state internally. It updates the hit, miss, eviction and writeback counters that the display layer renders. Associativity, address split and write-allocate policy are build-time choices.

## Interface
- `TAG_W`, 17: tag width in bits.
- `INDEX_W`, 11: set index width in bits; the block holds 2^INDEX_W sets.
- `WAYS`, 4: associativity; must be a power of 2 in the range 1..8. `AGE_W` = max(1, log2(WAYS)).
- `WRITE_ALLOC`, 1: 1 means a store miss allocates a line; 0 means a store miss does not allocate.
- `CNT_W`, 32: width of every statistics counter.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, **synchronous, active-low**.
- `start`  in  1  level input; no access is accepted while it is low.
- `clear`  in  1  synchronous clear of the counters only.
- `acc_valid`  in  1  an access is presented.
- `acc_ready`  out  1  the block can accept an access.
- `acc_tag`  in  TAG_W  access tag.
- `acc_index`  in  INDEX_W  access set index.
- `acc_store`  in  1  1 = store, 0 = load.
- `busy`  out  1  high in INIT, LOOKUP and UPDATE.
- `accesses_total`, `hit_total`, `miss_total`  out  CNT_W each  access counters.
- `read_hit_total`, `write_hit_total`, `read_miss_total`, `write_miss_total`  out  CNT_W each  per-type counters.
- `eviction_total`, `writeback_total`  out  CNT_W each  replacement counters.

## Operation
- FSM states: INIT, IDLE, LOOKUP, UPDATE.
- **INIT** (entered on reset):
  - Sweeps sets 0 .. 2^INDEX_W−1, one set per cycle.
  - For each set: clears valid and dirty, and sets the age of way w to w.
  - Goes to IDLE after the last set.
- **IDLE**:
  - `acc_ready` = `start`.
  - When `acc_valid` and `acc_ready` are both high, the block latches tag, index and store, issues the set read, and goes to LOOKUP.
- **LOOKUP**:
  - Set data arrives from the synchronous-read array.
  - All ways are compared in parallel: hit = valid and tag equal.
  - At most one way can match; the lowest-index match is used.
- **Victim selection on a miss:**
  - The lowest-index invalid way, if any.
  - Otherwise the way whose age is WAYS−1.
- **UPDATE**, performs one set write plus the counter increments:
  - Hit: ages below the hit way's age increment by 1; the hit way's age becomes 0. A store sets dirty.
  - Allocating miss:
    - The selected way gets valid=1, tag=new tag and dirty=`acc_store`.
    - The same age update is applied, using the selected way's old age.
    - If the replaced line was valid, `eviction_total` increments.
    - If it was also dirty, `writeback_total` increments.
  - Store miss with WRITE_ALLOC=0: the set is left unchanged (no LRU change, no eviction); only the miss counters move.
- **Age invariant:** the ages within a set are always a permutation of 0..WAYS−1.
- **Counters:**
  - Every accepted access increments `accesses_total`, then `hit_total` or `miss_total`, then exactly one of the four read/write hit/miss counters.
  - All counters saturate at 2^CNT_W−1 and do not wrap.
- **`clear`:**
  - Zeroes all counters the following cycle.
  - Cache contents are unchanged.
  - If `clear` coincides with an UPDATE increment, the clear wins.
- **WAYS=1:** the design degenerates to direct-mapped. The age logic is inert, and every conflicting miss on a valid line is an eviction.

## Timing
- **Reset values:**
  - All counters are 0.
  - `acc_ready`=0, `busy`=1.
  - State = INIT; the sweep always restarts from set 0.
- **INIT duration:** exactly 2^INDEX_W cycles after `resetn` deasserts. The first `acc_ready`=1 can occur on the next cycle.
- **Reset mid-operation:** the access in flight is abandoned and counts nothing; the block re-enters INIT.
- **Access timing:**
  - An access is accepted at edge N.
  - `acc_ready` is low from N.
  - Counters and array state are updated at edge N+2.
  - `acc_ready` returns high after N+2 (if `start` is high).
- **Throughput:** one access per 3 cycles.
- **Inputs:** `acc_*` are sampled only at acceptance; changes while `acc_ready`=0 are ignored.
- **`start` low:** holds IDLE and never aborts an in-flight access.
- **Back-to-back accesses** to the same set see the prior UPDATE, because the write completes before the next read is issued.

## Test plan
- **Reset and INIT:** deassert reset with INDEX_W=3 → `acc_ready` stays 0 for exactly 8 cycles; all counters read 0.
- **Cold fill, WAYS=4, index 5:**
  - Stimulus: loads of tags 1,2,3,4, then load tag 1.
  - Required: `miss_total`=4, `hit_total`=1, `read_hit_total`=1, `eviction_total`=0.
- **LRU victim, continuing the previous scenario:**
  - Load tag 5 → evicts tag 2 (the LRU way); `eviction_total`=1.
  - Load tag 2 → miss, evicting tag 3.
- **Dirty writeback:**
  - Stimulus: store tag 9 into an empty set, then loads of 4 other tags into that set.
  - Required: `write_miss_total`=1, `eviction_total`=1, `writeback_total`=1.
- **WRITE_ALLOC=0:** store tag 7 then load tag 7 → `write_miss_total`=1, `read_miss_total`=1, `hit_total`=0.
- **Clear, saturation and mid-access reset:**
  - `clear` asserted during UPDATE → counters all read 0.
  - Counter forced to 0xFFFFFFFF plus one more hit → it stays 0xFFFFFFFF.
  - Reset asserted in LOOKUP → `accesses_total`=0 after INIT.
